hyperbus_wb_bridge: RTL and testbench



---
 rtl/hyperbus_pkg.sv | 25 ++
 rtl/hyperbus_watchdog.sv | 45 ++++
 rtl/hyperbus_wb_bridge.sv | 199 +++++++++++++++++++
 tb/tb_hyperbus_wb_bridge.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the Wishbone-to-HyperBus bridge.
// One-hot sequencer states, beat indices, byte-select constant and the
// default watchdog limit.
package hyperbus_pkg;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_REQ   = 6'b000010,
        ST_WDATA = 6'b000100,
        ST_RDATA = 6'b001000,
        ST_DONE  = 6'b010000,
        ST_ERR   = 6'b100000
    } state_e;

    localparam logic       BEAT_LO         = 1'b0;
    localparam logic       BEAT_HI         = 1'b1;
    localparam logic [3:0] SEL_FULL        = 4'hF;
    localparam int         DEFAULT_TIMEOUT = 255;

    // States in which a HyperBus transaction is outstanding.
    function automatic logic is_active(state_e s);
        return (s == ST_REQ) || (s == ST_WDATA) || (s == ST_RDATA) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/hyperbus_watchdog.sv
// Loadable down-counter with expiry flag, used to bound every wait of the
// bridge. Only compiled when HYPERBUS_WB_TIMEOUT_EN is defined.
`ifdef HYPERBUS_WB_TIMEOUT_EN
module hyperbus_watchdog
    import hyperbus_pkg::*;
#(
    parameter int COUNT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic expired_o
);

    localparam int CW = (COUNT < 1) ? 1 : $clog2(COUNT + 1);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Next count: reload has priority, otherwise count down and stick at zero.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(COUNT);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            cnt_q <= CW'(COUNT);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule
`endif

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone B3 classic slave that turns each 32-bit access into one
// two-beat HyperBus controller transaction. All outputs are registered.
// Optional watchdog: define HYPERBUS_WB_TIMEOUT_EN.
module hyperbus_wb_bridge
    import hyperbus_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int TIMEOUT_COUNT = DEFAULT_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic [31:0]          hb_addr,
    output logic [2*WIDTH-1:0]   hb_din,
    input  logic [2*WIDTH-1:0]   hb_dout,
    input  logic                 hb_dready,
    input  logic                 hb_dvalid,
    input  logic                 hb_busy,
    output logic                 hb_wrq,
    output logic                 hb_rrq
);

    localparam int BW = 2 * WIDTH;

    state_e         state_q;
    logic           beat_q;
    logic           we_q;
    logic           abort_q;
    logic [31:0]    wdat_q;
    logic [31:0]    rdat_q;
    logic [31:0]    wb_dat_q;
    logic           wb_ack_q;
    logic           wb_err_q;
    logic [31:0]    hb_addr_q;
    logic [BW-1:0]  hb_din_q;
    logic           hb_wrq_q;
    logic           hb_rrq_q;
    logic           start;
    logic           wd_expired;
    logic           unused_adr;

    // Byte offset within the word is irrelevant: the controller addresses halfwords.
    assign unused_adr = ^wb_adr_i[1:0];

    // A new access is only taken once the previous termination pulse is over.
    assign start = wb_cyc_i & wb_stb_i & ~wb_ack_q & ~wb_err_q;

`ifdef HYPERBUS_WB_TIMEOUT_EN
    state_e wd_seen_q;
    logic   wd_active;
    logic   wd_load;
    logic   wd_raw;

    // Remembers last cycle's state so a state change reloads the watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_seen_q <= ST_IDLE;
        end else begin
            wd_seen_q <= state_q;
        end
    end

    assign wd_active = is_active(state_q);
    assign wd_load   = ~wd_active | (state_q != wd_seen_q);

    hyperbus_watchdog #(
        .COUNT     (TIMEOUT_COUNT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .load_i    (wd_load),
        .dec_i     (wd_active),
        .expired_o (wd_raw)
    );

    // Ignore a stale zero left over in the cycle right after a state change.
    assign wd_expired = wd_raw & wd_active & (state_q == wd_seen_q);
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_COUNT != 0);
    assign wd_expired     = 1'b0;
`endif

    // Transaction sequencer; every output register is written here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            beat_q    <= BEAT_LO;
            we_q      <= 1'b0;
            abort_q   <= 1'b0;
            wdat_q    <= '0;
            rdat_q    <= '0;
            wb_dat_q  <= '0;
            wb_ack_q  <= 1'b0;
            wb_err_q  <= 1'b0;
            hb_addr_q <= '0;
            hb_din_q  <= '0;
            hb_wrq_q  <= 1'b0;
            hb_rrq_q  <= 1'b0;
        end else begin
            wb_ack_q <= 1'b0;
            wb_err_q <= 1'b0;
            // The HyperBus side cannot be aborted; remember that the master left.
            if ((state_q != ST_IDLE) && (state_q != ST_ERR) && !wb_cyc_i) begin
                abort_q <= 1'b1;
            end
            if (wd_expired) begin
                state_q  <= ST_ERR;
                hb_wrq_q <= 1'b0;
                hb_rrq_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if (wb_we_i && (wb_sel_i != SEL_FULL)) begin
                                state_q <= ST_ERR;
                            end else begin
                                hb_addr_q <= {1'b0, wb_adr_i[31:2], 1'b0};
                                wdat_q    <= wb_dat_i;
                                hb_din_q  <= wb_dat_i[BW-1:0];
                                we_q      <= wb_we_i;
                                beat_q    <= BEAT_LO;
                                abort_q   <= 1'b0;
                                hb_wrq_q  <= wb_we_i;
                                hb_rrq_q  <= ~wb_we_i;
                                state_q   <= ST_REQ;
                            end
                        end
                    end
                    ST_REQ: begin
                        // Read strobe stays up: the controller samples it until completion.
                        if (hb_busy) begin
                            hb_wrq_q <= 1'b0;
                            state_q  <= we_q ? ST_WDATA : ST_RDATA;
                        end
                    end
                    ST_WDATA: begin
                        if (hb_dready) begin
                            if (beat_q == BEAT_LO) begin
                                beat_q   <= BEAT_HI;
                                hb_din_q <= wdat_q[2*BW-1:BW];
                            end else begin
                                state_q <= ST_DONE;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (hb_dvalid) begin
                            if (beat_q == BEAT_LO) begin
                                rdat_q[BW-1:0] <= hb_dout;
                                beat_q         <= BEAT_HI;
                            end else begin
                                rdat_q[2*BW-1:BW] <= hb_dout;
                                state_q           <= ST_DONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (!hb_busy) begin
                            hb_rrq_q <= 1'b0;
                            state_q  <= ST_IDLE;
                            if (!abort_q && wb_cyc_i) begin
                                wb_ack_q <= 1'b1;
                                if (!we_q) begin
                                    wb_dat_q <= rdat_q;
                                end
                            end
                        end
                    end
                    ST_ERR: begin
                        wb_err_q <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign wb_dat_o = wb_dat_q;
    assign wb_ack_o = wb_ack_q;
    assign wb_err_o = wb_err_q;
    assign hb_addr  = hb_addr_q;
    assign hb_din   = hb_din_q;
    assign hb_wrq   = hb_wrq_q;
    assign hb_rrq   = hb_rrq_q;

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Self-checking bench for hyperbus_wb_bridge: directed and randomized
// Wishbone accesses against a behavioural HyperBus controller with a
// halfword memory, plus a word-level reference memory for expected data.
module tb_hyperbus_wb_bridge;

`ifdef HYPERBUS_WB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 255;
`endif
    localparam int BUDGET = 200;

    logic        clk;
    logic        rst;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [31:0] hb_addr;
    logic [15:0] hb_din;
    logic [15:0] hb_dout;
    logic        hb_dready;
    logic        hb_dvalid;
    logic        hb_busy;
    logic        hb_wrq;
    logic        hb_rrq;

    hyperbus_wb_bridge #(
        .WIDTH         (8),
        .TIMEOUT_COUNT (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_we_i   (wb_we_i),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_dat_o  (wb_dat_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .hb_addr   (hb_addr),
        .hb_din    (hb_din),
        .hb_dout   (hb_dout),
        .hb_dready (hb_dready),
        .hb_dvalid (hb_dvalid),
        .hb_busy   (hb_busy),
        .hb_wrq    (hb_wrq),
        .hb_rrq    (hb_rrq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural HyperBus controller ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [15:0] b0;
        logic [15:0] b1;
    } txn_t;

    typedef enum {C_IDLE, C_START, C_BEAT, C_TAIL, C_RELEASE} ctl_e;

    logic [15:0] mem_h [logic [31:0]];
    txn_t        log_q [$];
    bit          mute = 1'b0;

    initial begin
        ctl_e        c_st;
        txn_t        cur;
        int          wait_n;
        int          beat;
        bit          junk;
        logic [31:0] a;
        logic [15:0] hw;
        hb_busy   = 1'b0;
        hb_dready = 1'b0;
        hb_dvalid = 1'b0;
        hb_dout   = '0;
        c_st      = C_IDLE;
        wait_n    = 0;
        beat      = 0;
        junk      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            hb_dready = 1'b0;
            hb_dvalid = 1'b0;
            if (rst) begin
                hb_busy = 1'b0;
                c_st    = C_IDLE;
            end else begin
                case (c_st)
                    C_IDLE: begin
                        if (!mute && (hb_rrq || hb_wrq)) begin
                            cur.we   = hb_wrq;
                            cur.addr = hb_addr;
                            wait_n   = $urandom_range(0, 3);
                            c_st     = C_START;
                        end
                    end
                    C_START: begin
                        if (wait_n == 0) begin
                            hb_busy = 1'b1;
                            wait_n  = 1 + $urandom_range(0, 2);
                            beat    = 0;
                            c_st    = C_BEAT;
                        end else begin
                            wait_n--;
                        end
                    end
                    C_BEAT: begin
                        wait_n--;
                        if (wait_n == 0) begin
                            a = cur.addr + beat;
                            if (cur.we) begin
                                hb_dready = 1'b1;
                                hw        = hb_din;
                            end else begin
                                if (mem_h.exists(a)) hw = mem_h[a];
                                else                 hw = 16'($urandom);
                                mem_h[a]  = hw;
                                hb_dvalid = 1'b1;
                                hb_dout   = hw;
                            end
                            if (beat == 0) cur.b0 = hw;
                            else           cur.b1 = hw;
                            if (beat == 1) begin
                                c_st   = C_TAIL;
                                wait_n = $urandom_range(0, 2);
                                junk   = !cur.we && ($urandom_range(0, 1) == 1);
                            end else begin
                                beat   = 1;
                                wait_n = 1 + $urandom_range(0, 1);
                            end
                        end
                    end
                    C_TAIL: begin
                        if (junk) begin
                            hb_dvalid = 1'b1;
                            hb_dout   = 16'($urandom);
                            junk      = 1'b0;
                        end
                        if (wait_n == 0) begin
                            hb_busy = 1'b0;
                            if (cur.we) begin
                                mem_h[cur.addr]     = cur.b0;
                                mem_h[cur.addr + 1] = cur.b1;
                            end
                            log_q.push_back(cur);
                            c_st = C_RELEASE;
                        end else begin
                            wait_n--;
                        end
                    end
                    C_RELEASE: begin
                        if (!hb_rrq && !hb_wrq) c_st = C_IDLE;
                    end
                    default: c_st = C_IDLE;
                endcase
            end
        end
    end

    // ---------------- monitors ----------------
    int overlap = 0;
    always @(negedge clk) begin
        if (wb_ack_o && wb_err_o) overlap++;
    end

    // ---------------- Wishbone master ----------------
    logic [31:0] ref_mem [logic [31:0]];

    bit          acc_done;
    int          acc_ack;
    int          acc_err;
    int          acc_lat;
    logic        acc_rq1;
    logic        acc_rq_end;
    logic        acc_wrq_seen;
    logic [31:0] acc_rdata;
    logic        acc_rq_after;
    logic        acc_term_again;

    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input bit hold);
        int n;
        acc_done = 0; acc_ack = 0; acc_err = 0; acc_lat = 0;
        acc_rq1 = 0; acc_rq_end = 0; acc_wrq_seen = 0; acc_rdata = '0;
        acc_rq_after = 0; acc_term_again = 0;
        @(posedge clk);
        #2;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        n = 0;
        while (!acc_done && n < BUDGET) begin
            @(posedge clk);
            #2;
            n++;
            if (n == 1) acc_rq1 = hb_rrq | hb_wrq;
            if (hb_wrq) acc_wrq_seen = 1'b1;
            if (wb_ack_o) acc_ack++;
            if (wb_err_o) acc_err++;
            if (wb_ack_o || wb_err_o) begin
                acc_done   = 1;
                acc_lat    = n;
                acc_rdata  = wb_dat_o;
                acc_rq_end = hb_rrq | hb_wrq;
            end
        end
        if (hold && acc_done) begin
            @(posedge clk);
            #2;
            acc_rq_after   = hb_rrq | hb_wrq;
            acc_term_again = wb_ack_o | wb_err_o;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    // Runs one access and checks it against the reference memory.
    task automatic run_and_check(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input bit hold);
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        txn_t        e;
        exp_addr = (adr >> 1) & 32'hFFFF_FFFE;
        log_q.delete();
        wb_access(we, adr, dat, sel, hold);
        check("terminated", 64'(acc_done), 64'd1);
        if (we && sel != 4'hF) begin
            check("perr_err", 64'(acc_err), 64'd1);
            check("perr_ack", 64'(acc_ack), 64'd0);
            check("perr_lat", 64'(acc_lat), 64'd2);
            check("perr_wrq", 64'(acc_wrq_seen), 64'd0);
            check("perr_txn", 64'(log_q.size()), 64'd0);
        end else begin
            check("ack", 64'(acc_ack), 64'd1);
            check("err", 64'(acc_err), 64'd0);
            check("req_lat", 64'(acc_rq1), 64'd1);
            check("txn_cnt", 64'(log_q.size()), 64'd1);
            if (log_q.size() > 0) begin
                e = log_q.pop_front();
                check("txn_we", 64'(e.we), 64'(we));
                check("txn_addr", 64'(e.addr), 64'(exp_addr));
                if (we) begin
                    check("wbeat0", 64'(e.b0), 64'(dat[15:0]));
                    check("wbeat1", 64'(e.b1), 64'(dat[31:16]));
                    ref_mem[exp_addr] = dat;
                end else begin
                    if (ref_mem.exists(exp_addr)) exp_data = ref_mem[exp_addr];
                    else                          exp_data = {e.b1, e.b0};
                    check("rdata", 64'(acc_rdata), 64'(exp_data));
                    ref_mem[exp_addr] = exp_data;
                end
            end
        end
        if (hold && acc_done) begin
            check("no_reaccept", 64'(acc_rq_after), 64'd0);
            check("single_pulse", 64'(acc_term_again), 64'd0);
        end
    endtask

    initial begin
        int          n;
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        bit          seen_ack;
        txn_t        e;
        logic [31:0] key;

        rst      = 1'b1;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        wb_we_i  = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        #1;
        check("reset_wb", 64'({wb_ack_o, wb_err_o, wb_dat_o}), 64'd0);
        check("reset_hb", 64'({hb_wrq, hb_rrq, hb_addr, hb_din}), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;

        // Directed read: controller memory holds 0x1234 / 0xABCD at halfword 8.
        mem_h[32'h8]      = 16'h1234;
        mem_h[32'h9]      = 16'hABCD;
        ref_mem[32'h8]    = 32'hABCD_1234;
        run_and_check(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0);

        // Full write then readback, partial write error.
        run_and_check(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 1'b1);
        run_and_check(1'b0, 32'h0000_0023, 32'h0, 4'h1, 1'b0);
        run_and_check(1'b1, 32'h0000_0024, 32'h1111_2222, 4'h3, 1'b1);

        // Master abort during the read data phase.
        log_q.delete();
        @(posedge clk);
        #2;
        wb_we_i = 1'b0; wb_adr_i = 32'h0000_0040; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        seen_ack = 0;
        n = 0;
        while (!hb_busy && n < BUDGET) begin
            @(posedge clk); #2; n++;
            if (wb_ack_o) seen_ack = 1;
        end
        check("abort_busy_seen", 64'(hb_busy), 64'd1);
        @(posedge clk); #2;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        n = 0;
        while ((log_q.size() == 0 || hb_rrq) && n < BUDGET) begin
            @(posedge clk); #2; n++;
            if (wb_ack_o) seen_ack = 1;
        end
        repeat (3) begin
            @(posedge clk); #2;
            if (wb_ack_o) seen_ack = 1;
        end
        check("abort_no_ack", 64'(seen_ack), 64'd0);
        check("abort_txn_done", 64'(log_q.size()), 64'd1);
        check("abort_rrq_low", 64'(hb_rrq), 64'd0);
        if (log_q.size() > 0) begin
            e   = log_q.pop_front();
            key = 32'h20;
            if (!ref_mem.exists(key)) ref_mem[key] = {e.b1, e.b0};
        end
        run_and_check(1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b0);

        // Reset in the middle of a write data phase.
        log_q.delete();
        @(posedge clk); #2;
        wb_we_i = 1'b1; wb_adr_i = 32'h0000_0080; wb_dat_i = 32'hCAFE_F00D; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        n = 0;
        while (!hb_busy && n < BUDGET) begin
            @(posedge clk); #2; n++;
        end
        check("rst_busy_seen", 64'(hb_busy), 64'd1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("midrst_wb", 64'({wb_ack_o, wb_err_o, wb_dat_o}), 64'd0);
        check("midrst_hb", 64'({hb_wrq, hb_rrq, hb_addr, hb_din}), 64'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        check("midrst_no_txn", 64'(log_q.size()), 64'd0);
        run_and_check(1'b1, 32'h0000_0090, 32'h0BAD_CAFE, 4'hF, 1'b0);
        run_and_check(1'b0, 32'h0000_0090, 32'h0, 4'hF, 1'b0);

`ifdef HYPERBUS_WB_TIMEOUT_EN
        // Watchdog: controller never answers.
        mute = 1'b1;
        log_q.delete();
        wb_access(1'b0, 32'h0000_0100, 32'h0, 4'hF, 1'b0);
        check("wd_err", 64'(acc_err), 64'd1);
        check("wd_ack", 64'(acc_ack), 64'd0);
        check("wd_lat_ok", 64'(acc_lat >= TB_TIMEOUT && acc_lat <= TB_TIMEOUT + 8), 64'd1);
        check("wd_rrq_low", 64'(acc_rq_end), 64'd0);
        mute = 1'b0;
        run_and_check(1'b0, 32'h0000_0010, 32'h0, 4'hF, 1'b0);
`endif

        // Randomized accesses over a small address window (bit 31 toggled too).
        for (int i = 0; i < 40; i++) begin
            we  = ($urandom_range(0, 1) == 1);
            adr = {1'($urandom_range(0, 1)), 23'd0, 4'($urandom_range(0, 7)), 4'($urandom)};
            if (we) begin
                if ($urandom_range(0, 3) == 0) sel = 4'($urandom_range(0, 14));
                else                           sel = 4'hF;
            end else begin
                sel = 4'($urandom);
            end
            run_and_check(we, adr, $urandom, sel, ($urandom_range(0, 2) == 0));
        end

        check("ack_err_overlap", 64'(overlap), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
